ts_pid_filter: RTL and testbench
================================

TS_PID_FILTER -- requirements
Module: ts_pid_filter

Interface
REQ-001 Parameters: NUM_FILT, default 8, number of PID filter entries (1..32).
REQ-002 Parameters: OUT_W, default 32, output word width, one of 8/16/32.
REQ-003 Parameters: FIFO_DEPTH, default 128, output FIFO depth in words, power of two, >= 2*WPP where WPP = 188*8/OUT_W.
REQ-004 Ports, clock and reset first:
- dmx_clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- fr_ts_sync  in  1  marks byte 0 of a TS packet.
- fr_ts_dvalid  in  1  byte strobe.
- fr_ts_di  in  8  TS byte.
- fr_ts_derr  in  1  byte error flag.
- filt_mode  in  1  0 = pass matched PIDs only; 1 = pass all packets.
- cfg_we  in  1  filter table write strobe.
- cfg_idx  in  clog2(NUM_FILT)  entry index.
- cfg_pid  in  13  PID value.
- cfg_en  in  1  entry enable.
- out_data  out  OUT_W  packet word, first byte in MSBs.
- out_last  out  1  last word of a packet.
- out_valid  out  1  word available.
- out_ready  in  1  sink accepts.
- pkt_cnt  out  32  committed packets, wrapping.
- drop_cnt  out  16  dropped packets, saturating at 0xFFFF.
- out_int  out  1  one-cycle pulse per overflow drop.

Function
REQ-005 An input byte is accepted only in a cycle with fr_ts_dvalid=1; no timeout applies while fr_ts_dvalid is low.
REQ-006 States: IDLE, HDR, BODY, SKIP.
- IDLE: accepted byte with fr_ts_sync=1 and value 0x47 starts a packet.
- Any other byte in IDLE is ignored.
REQ-007 Packet start: if FIFO free space (relative to the speculative write pointer) < WPP, increment drop_cnt, pulse out_int, go to SKIP; otherwise write the byte speculatively and go to HDR.
REQ-008 Speculative write: bytes pack MSB-first into words written at wr_spec.
- Only wr_commit is visible to the read side.
- Abort sets wr_spec := wr_commit.
REQ-009 HDR: bytes 1 and 2 are written speculatively. On byte 2, PID = {byte1[4:0], byte2}.
- Keep the packet (go to BODY) if filt_mode=1 or any enabled entry matches.
- Otherwise abort and go to SKIP; no counter change.
REQ-010 BODY: on byte 187 the final word is written with out_last=1, wr_commit := wr_spec + 1 word, pkt_cnt increments, and the state returns to IDLE.
- The word is visible on out_valid the next cycle.
REQ-011 fr_ts_derr=1 on any accepted byte of a packet in HDR or BODY: abort, increment drop_cnt, go to SKIP.
REQ-012 fr_ts_sync=1 on an accepted byte in HDR, BODY or SKIP: abort any in-flight packet, with no counter change; that byte is then evaluated as in IDLE in the same cycle.
REQ-013 SKIP leaves only via REQ-012.
REQ-014 Filter table: cfg_we writes {cfg_en, cfg_pid} into entry cfg_idx. A write in the same cycle as a byte-2 decision takes effect after that decision.
REQ-015 Output FIFO: standard valid/ready. A word is transferred when out_valid && out_ready. out_data and out_last hold stable while out_valid=1 && out_ready=0.
REQ-016 Pointers carry one extra wrap bit; full/empty are derived from it, so the FIFO never overwrites uncommitted-read data.
REQ-017 Simultaneous read and speculative or commit write in one cycle are both honoured.

Reset
REQ-018 rst_n low forces, asynchronously:
- state=IDLE.
- All pointers 0.
- out_valid=0, out_last=0, out_data=0.
- pkt_cnt=0, drop_cnt=0, out_int=0.
- All filter entries disabled, PID 0.
REQ-019 Reset during a packet discards it. After release, nothing is output until a new 0x47 sync byte is accepted.

Verification
REQ-020 Table entry 0 = PID 0x100 enabled, filt_mode=0, OUT_W=32. Send one packet with PID 0x100, bytes 0x47,0x01,0x00,... -> 47 words, first word 0x47010000, out_last on word 47, pkt_cnt=1.
REQ-021 Send PID 0x101 with filt_mode=0 -> no output, pkt_cnt=0, drop_cnt=0. Repeat with filt_mode=1 -> 47 words, pkt_cnt=1.
REQ-022 fr_ts_derr on byte 100 of a matching packet -> no output, drop_cnt=1. The following clean packet is output intact.
REQ-023 Hold out_ready=0 and send 3 matching packets with FIFO_DEPTH=128 -> packets 1-2 committed, packet 3 dropped, out_int pulses once, drop_cnt=1. Then release out_ready -> exactly 94 words.
REQ-024 Sync asserted at byte 50 of a matching packet -> first packet discarded, the new packet is output in full, pkt_cnt=1. Separately, assert rst_n low mid-packet -> all outputs and counters read 0 and nothing is output before the next sync.

Source files
------------

// File: rtl/ts_pid_filter.sv
`default_nettype none
// ============================================================================
// ts_pid_filter : MPEG-TS packet PID filter with speculative-write output FIFO
// Revision      : 1.0 - initial release
// ============================================================================
module ts_pid_filter #(
  parameter int NUM_FILT   = 8,
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 128,
  localparam int c_IDX_W   = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1
) (
  input  logic               dmx_clk,
  input  logic               rst_n,
  input  logic               fr_ts_sync,
  input  logic               fr_ts_dvalid,
  input  logic [7:0]         fr_ts_di,
  input  logic               fr_ts_derr,
  input  logic               filt_mode,
  input  logic               cfg_we,
  input  logic [c_IDX_W-1:0] cfg_idx,
  input  logic [12:0]        cfg_pid,
  input  logic               cfg_en,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        pkt_cnt,
  output logic [15:0]        drop_cnt,
  output logic               out_int
);

  localparam int c_BPW = OUT_W / 8;
  localparam int c_WPP = 188 / c_BPW;
  localparam int c_AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_BODY = 2'd2,
    S_SKIP = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [OUT_W:0]     r_mem [FIFO_DEPTH];
  logic [c_AW:0]      r_rd_ptr;
  logic [c_AW:0]      r_wr_spec;
  logic [c_AW:0]      r_wr_commit;
  logic [7:0]         r_bcnt;
  logic [4:0]         r_pid_hi;
  logic [12:0]        r_tbl_pid [NUM_FILT];
  logic [NUM_FILT-1:0] r_tbl_en;

  logic               w_start;
  logic               w_wr;
  logic               w_abort;
  logic               w_commit;
  logic               w_drop;
  logic               w_ovf;
  logic               w_match;
  logic               w_room;
  logic               w_word_done;
  logic [7:0]         w_pos;
  logic [c_AW:0]      w_used;
  logic [c_AW:0]      w_base;
  logic [12:0]        w_pid;
  logic [OUT_W-1:0]   w_word;
  logic [OUT_W:0]     w_rd_word;

  // Packet-start room check is against the committed pointer: any in-flight
  // speculative data is discarded before a new packet can start.
  assign w_used = r_wr_commit - r_rd_ptr;
  assign w_room = ({1'b0, w_used} + (c_AW+2)'(c_WPP)) <= (c_AW+2)'(FIFO_DEPTH);

  assign w_pid  = {r_pid_hi, fr_ts_di};

  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i < NUM_FILT; i++) begin
      if (r_tbl_en[i] && (r_tbl_pid[i] == w_pid)) begin
        w_match = 1'b1;
      end
    end
  end

  always_ff @(posedge dmx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_wr     = 1'b0;
    w_abort  = 1'b0;
    w_commit = 1'b0;
    w_drop   = 1'b0;
    w_ovf    = 1'b0;
    if (fr_ts_dvalid) begin
      if ((r_state == S_IDLE) || fr_ts_sync) begin
        w_abort = (r_state != S_IDLE);
        w_next  = S_IDLE;
        if (fr_ts_sync && (fr_ts_di == 8'h47)) begin
          if (w_room) begin
            w_start = 1'b1;
            w_wr    = 1'b1;
            w_next  = S_HDR;
          end else begin
            w_drop  = 1'b1;
            w_ovf   = 1'b1;
            w_next  = S_SKIP;
          end
        end
      end else if (r_state != S_SKIP) begin
        if (fr_ts_derr) begin
          w_abort = 1'b1;
          w_drop  = 1'b1;
          w_next  = S_SKIP;
        end else if ((r_state == S_HDR) && (r_bcnt == 8'd2) && !(filt_mode || w_match)) begin
          w_abort = 1'b1;
          w_next  = S_SKIP;
        end else begin
          w_wr = 1'b1;
          if ((r_state == S_HDR) && (r_bcnt == 8'd2)) begin
            w_next = S_BODY;
          end
          if ((r_state == S_BODY) && (r_bcnt == 8'd187)) begin
            w_commit = 1'b1;
            w_next   = S_IDLE;
          end
        end
      end
    end
  end

  assign w_pos       = w_start ? 8'd0 : r_bcnt;
  assign w_word_done = (w_pos & 8'(c_BPW - 1)) == 8'(c_BPW - 1);
  assign w_base      = w_abort ? r_wr_commit : r_wr_spec;

  generate
    if (OUT_W > 8) begin : g_pack
      logic [OUT_W-9:0] r_acc;
      assign w_word = {r_acc, fr_ts_di};
      always_ff @(posedge dmx_clk or negedge rst_n) begin
        if (!rst_n) begin
          r_acc <= '0;
        end else if (w_wr) begin
          r_acc <= w_word[OUT_W-9:0];
        end
      end
    end else begin : g_byte
      assign w_word = fr_ts_di;
    end
  endgenerate

  always_ff @(posedge dmx_clk) begin
    if (w_wr && w_word_done) begin
      r_mem[w_base[c_AW-1:0]] <= {w_commit, w_word};
    end
  end

  always_ff @(posedge dmx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_wr_spec   <= '0;
      r_wr_commit <= '0;
      r_bcnt      <= '0;
      r_pid_hi    <= '0;
      pkt_cnt     <= '0;
      drop_cnt    <= '0;
      out_int     <= 1'b0;
      r_tbl_en    <= '0;
      for (int i = 0; i < NUM_FILT; i++) begin
        r_tbl_pid[i] <= '0;
      end
    end else begin
      if (out_valid && out_ready) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_wr && w_word_done) begin
        r_wr_spec <= w_base + 1'b1;
      end else if (w_abort) begin
        r_wr_spec <= r_wr_commit;
      end
      if (w_commit) begin
        r_wr_commit <= w_base + 1'b1;
        pkt_cnt     <= pkt_cnt + 1'b1;
      end
      if (w_start) begin
        r_bcnt <= 8'd1;
      end else if (w_wr) begin
        r_bcnt <= r_bcnt + 1'b1;
      end
      // The byte written just before the byte-2 decision is byte 1.
      if (w_wr) begin
        r_pid_hi <= fr_ts_di[4:0];
      end
      if (w_drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
      out_int <= w_ovf;
      if (cfg_we && ({1'b0, cfg_idx} < (c_IDX_W+1)'(NUM_FILT))) begin
        r_tbl_pid[cfg_idx] <= cfg_pid;
        r_tbl_en[cfg_idx]  <= cfg_en;
      end
    end
  end

  assign out_valid = (r_wr_commit != r_rd_ptr);
  assign w_rd_word = r_mem[r_rd_ptr[c_AW-1:0]];
  assign out_data  = out_valid ? w_rd_word[OUT_W-1:0] : '0;
  assign out_last  = out_valid ? w_rd_word[OUT_W] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ts_pid_filter.sv
`default_nettype none
// ============================================================================
// tb_ts_pid_filter : self-checking bench for ts_pid_filter (OUT_W=32, depth 128)
// Revision         : 1.0 - initial release
// ============================================================================
module tb_ts_pid_filter;

  localparam int NUM_FILT   = 8;
  localparam int OUT_W      = 32;
  localparam int FIFO_DEPTH = 128;
  localparam int WPP        = 47;

  logic        dmx_clk = 1'b0;
  logic        rst_n;
  logic        fr_ts_sync, fr_ts_dvalid, fr_ts_derr, filt_mode;
  logic [7:0]  fr_ts_di;
  logic        cfg_we, cfg_en;
  logic [2:0]  cfg_idx;
  logic [12:0] cfg_pid;
  logic [31:0] out_data;
  logic        out_last, out_valid, out_ready;
  logic [31:0] pkt_cnt;
  logic [15:0] drop_cnt;
  logic        out_int;

  always #5 dmx_clk = ~dmx_clk;

  ts_pid_filter #(.NUM_FILT(NUM_FILT), .OUT_W(OUT_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .dmx_clk(dmx_clk), .rst_n(rst_n),
    .fr_ts_sync(fr_ts_sync), .fr_ts_dvalid(fr_ts_dvalid), .fr_ts_di(fr_ts_di),
    .fr_ts_derr(fr_ts_derr), .filt_mode(filt_mode),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pid(cfg_pid), .cfg_en(cfg_en),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .out_int(out_int)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [32:0] exp_q[$];
  logic [32:0] rx_q[$];
  int          m_pkt, m_drop, m_int, int_seen;
  logic [12:0] m_pid [NUM_FILT];
  logic        m_en  [NUM_FILT];
  logic        m_mode;

  always @(negedge dmx_clk) begin
    if (out_valid && out_ready) rx_q.push_back({out_last, out_data});
    if (out_int) int_seen++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit m_match(input logic [12:0] p);
    for (int i = 0; i < NUM_FILT; i++) if (m_en[i] && m_pid[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge dmx_clk); #1; end
  endtask

  task automatic model_clear();
    exp_q.delete(); rx_q.delete();
    m_pkt = 0; m_drop = 0; m_int = 0; int_seen = 0;
    for (int i = 0; i < NUM_FILT; i++) begin m_pid[i] = '0; m_en[i] = 1'b0; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fr_ts_sync = 0; fr_ts_dvalid = 0; fr_ts_derr = 0; fr_ts_di = 0;
    cfg_we = 0; cfg_en = 0; cfg_idx = 0; cfg_pid = 0;
    filt_mode = 0; m_mode = 0; out_ready = 1;
    #2;
    idle(2);
    model_clear();
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic cfg_write(input int idx, input logic [12:0] pid, input logic en);
    cfg_we = 1; cfg_idx = 3'(idx); cfg_pid = pid; cfg_en = en;
    idle(1);
    cfg_we = 0;
    m_pid[idx] = pid; m_en[idx] = en;
  endtask

  task automatic put_byte(input logic [7:0] b, input logic s, input logic e);
    fr_ts_di = b; fr_ts_sync = s; fr_ts_derr = e; fr_ts_dvalid = 1;
    idle(1);
    fr_ts_dvalid = 0; fr_ts_sync = 0; fr_ts_derr = 0; cfg_we = 0;
  endtask

  // Sends one packet (cut short at byte cut_at) and predicts its fate.
  task automatic send_pkt(input logic [12:0] pid, input int err_at, input int cut_at,
                          input bit rnd, input bit zero_pay, input int cfg_at);
    logic [7:0] b [188];
    bit ovf, keep, live;
    int occ;
    b[0] = 8'h47;
    b[1] = {(zero_pay ? 3'b000 : 3'($urandom)), pid[12:8]};
    b[2] = pid[7:0];
    for (int i = 3; i < 188; i++) b[i] = zero_pay ? 8'h00 : 8'($urandom);
    ovf = 0; keep = 0; live = 0;
    for (int i = 0; i < 188; i++) begin
      if (i == cut_at) return;
      if (rnd) begin
        if ($urandom_range(0, 3) == 0) begin
          out_ready = ($urandom_range(0, 4) == 0);
          idle(1);
        end
        out_ready = ($urandom_range(0, 4) == 0);
      end
      if (i == 0) begin
        occ  = exp_q.size() - rx_q.size();
        ovf  = (FIFO_DEPTH - occ) < WPP;
        keep = !ovf && (m_mode || m_match(pid));
        live = !ovf;
        if (ovf) begin m_int++; if (m_drop < 65535) m_drop++; end
      end
      if (i == err_at && i >= 1 && live && (i <= 2 || keep)) begin
        live = 0;
        if (m_drop < 65535) m_drop++;
      end else if (i == 2 && live && !keep) begin
        live = 0;
      end
      if (i == 187 && live) begin
        for (int w = 0; w < WPP; w++)
          exp_q.push_back({(w == WPP - 1), b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]});
        m_pkt++;
      end
      if (i == cfg_at) begin cfg_we = 1; cfg_idx = 3'd1; cfg_pid = pid; cfg_en = 1; end
      put_byte(b[i], (i == 0), (i == err_at));
      if (i == cfg_at) begin m_pid[1] = pid; m_en[1] = 1'b1; end
    end
  endtask

  task automatic drain(output bit to);
    int t = 0;
    out_ready = 1;
    while (rx_q.size() < exp_q.size() && t < 3000) begin idle(1); t++; end
    idle(8);
    to = (rx_q.size() != exp_q.size());
  endtask

  task automatic test_reset();
    do_reset();
    n_checks += 6;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    if (out_last !== 1'b0) begin n_errors++; $display("FAIL reset_last: got %b want 0", out_last); end
    if (out_data !== 32'h0) begin n_errors++; $display("FAIL reset_data: got %h want 0", out_data); end
    if (pkt_cnt !== 32'h0) begin n_errors++; $display("FAIL reset_pkt: got %0d want 0", pkt_cnt); end
    if (drop_cnt !== 16'h0) begin n_errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    if (out_int !== 1'b0) begin n_errors++; $display("FAIL reset_int: got %b want 0", out_int); end
  endtask

  task automatic test_basic();
    bit to; int lasts = 0; int d;
    do_reset();
    cfg_write(0, 13'h100, 1);
    send_pkt(13'h100, -1, -1, 0, 1, -1);
    drain(to);
    n_checks++;
    if (to || rx_q.size() != 47) begin n_errors++; $display("FAIL basic_words: got %0d want 47", rx_q.size()); end
    if (rx_q.size() == 47) begin
      for (int i = 0; i < 47; i++) lasts += rx_q[i][32];
      n_checks += 3;
      if (rx_q[0][31:0] !== 32'h47010000) begin n_errors++; $display("FAIL basic_first: got %h want 47010000", rx_q[0][31:0]); end
      if (rx_q[46][32] !== 1'b1 || lasts != 1) begin n_errors++; $display("FAIL basic_last: last47=%b count=%0d want 1/1", rx_q[46][32], lasts); end
      d = first_diff();
      if (d != -1) begin n_errors++; $display("FAIL basic_stream: word %0d got %h want %h", d, rx_q[d], exp_q[d]); end
    end
    n_checks++;
    if (pkt_cnt !== 32'd1) begin n_errors++; $display("FAIL basic_pkt: got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_filter();
    bit to; int d;
    do_reset();
    cfg_write(0, 13'h100, 1);
    send_pkt(13'h101, -1, -1, 0, 0, -1);
    drain(to);
    n_checks += 3;
    if (rx_q.size() != 0) begin n_errors++; $display("FAIL filt_nomatch_words: got %0d want 0", rx_q.size()); end
    if (pkt_cnt !== 32'd0) begin n_errors++; $display("FAIL filt_nomatch_pkt: got %0d want 0", pkt_cnt); end
    if (drop_cnt !== 16'd0) begin n_errors++; $display("FAIL filt_nomatch_drop: got %0d want 0", drop_cnt); end
    filt_mode = 1; m_mode = 1;
    send_pkt(13'h101, -1, -1, 0, 0, -1);
    drain(to);
    d = first_diff();
    n_checks += 3;
    if (to || rx_q.size() != 47) begin n_errors++; $display("FAIL filt_all_words: got %0d want 47", rx_q.size()); end
    if (d != -1) begin n_errors++; $display("FAIL filt_all_stream: first bad word %0d", d); end
    if (pkt_cnt !== 32'd1) begin n_errors++; $display("FAIL filt_all_pkt: got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_derr();
    bit to; int d;
    do_reset();
    cfg_write(0, 13'h100, 1);
    send_pkt(13'h100, 100, -1, 0, 0, -1);
    idle(5);
    n_checks += 2;
    if (rx_q.size() != 0) begin n_errors++; $display("FAIL derr_words: got %0d want 0", rx_q.size()); end
    if (drop_cnt !== 16'd1) begin n_errors++; $display("FAIL derr_drop: got %0d want 1", drop_cnt); end
    send_pkt(13'h100, -1, -1, 0, 0, -1);
    drain(to);
    d = first_diff();
    n_checks += 3;
    if (to || rx_q.size() != 47 || d != -1) begin n_errors++; $display("FAIL derr_next: got %0d words bad=%0d want 47 bad=-1", rx_q.size(), d); end
    if (pkt_cnt !== 32'd1) begin n_errors++; $display("FAIL derr_pkt: got %0d want 1", pkt_cnt); end
    if (int_seen != 0) begin n_errors++; $display("FAIL derr_int: got %0d pulses want 0", int_seen); end
  endtask

  task automatic test_overflow();
    bit to; int d;
    do_reset();
    cfg_write(0, 13'h100, 1);
    out_ready = 0;
    for (int p = 0; p < 3; p++) send_pkt(13'h100, -1, -1, 0, 0, -1);
    idle(4);
    n_checks += 4;
    if (pkt_cnt !== 32'd2) begin n_errors++; $display("FAIL ovf_pkt: got %0d want 2", pkt_cnt); end
    if (drop_cnt !== 16'd1) begin n_errors++; $display("FAIL ovf_drop: got %0d want 1", drop_cnt); end
    if (int_seen != 1) begin n_errors++; $display("FAIL ovf_int: got %0d pulses want 1", int_seen); end
    if (rx_q.size() != 0) begin n_errors++; $display("FAIL ovf_held: got %0d words want 0", rx_q.size()); end
    drain(to);
    d = first_diff();
    n_checks += 2;
    if (to || rx_q.size() != 94) begin n_errors++; $display("FAIL ovf_words: got %0d want 94", rx_q.size()); end
    if (d != -1) begin n_errors++; $display("FAIL ovf_stream: first bad word %0d", d); end
  endtask

  task automatic test_resync();
    bit to; int d;
    do_reset();
    cfg_write(0, 13'h100, 1);
    send_pkt(13'h100, -1, 50, 0, 0, -1);
    send_pkt(13'h100, -1, -1, 0, 0, -1);
    drain(to);
    d = first_diff();
    n_checks += 3;
    if (to || rx_q.size() != 47 || d != -1) begin n_errors++; $display("FAIL resync_words: got %0d words bad=%0d want 47 bad=-1", rx_q.size(), d); end
    if (pkt_cnt !== 32'd1) begin n_errors++; $display("FAIL resync_pkt: got %0d want 1", pkt_cnt); end
    if (drop_cnt !== 16'd0) begin n_errors++; $display("FAIL resync_drop: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_cfg_collision();
    bit to;
    do_reset();
    cfg_write(1, 13'h0AB, 0);
    send_pkt(13'h0AB, -1, -1, 0, 0, 2);
    idle(4);
    n_checks++;
    if (pkt_cnt !== 32'd0 || rx_q.size() != 0) begin n_errors++; $display("FAIL cfg_same_cycle: got pkt=%0d words=%0d want 0/0", pkt_cnt, rx_q.size()); end
    send_pkt(13'h0AB, -1, -1, 0, 0, -1);
    drain(to);
    n_checks++;
    if (to || pkt_cnt !== 32'd1 || first_diff() != -1) begin n_errors++; $display("FAIL cfg_after: got pkt=%0d words=%0d want 1/47", pkt_cnt, rx_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit to;
    do_reset();
    cfg_write(0, 13'h100, 1);
    out_ready = 0;
    send_pkt(13'h100, -1, -1, 0, 0, -1);
    send_pkt(13'h100, -1, 90, 0, 0, -1);
    n_checks++;
    if (out_valid !== 1'b1 || pkt_cnt !== 32'd1) begin n_errors++; $display("FAIL rstmid_pre: got valid=%b pkt=%0d want 1/1", out_valid, pkt_cnt); end
    rst_n = 0;
    #2;
    n_checks += 3;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin n_errors++; $display("FAIL rstmid_flags: got valid=%b last=%b want 0/0", out_valid, out_last); end
    if (out_data !== 32'h0) begin n_errors++; $display("FAIL rstmid_data: got %h want 0", out_data); end
    if (pkt_cnt !== 32'd0 || drop_cnt !== 16'd0 || out_int !== 1'b0) begin n_errors++; $display("FAIL rstmid_cnt: got pkt=%0d drop=%0d int=%b want 0", pkt_cnt, drop_cnt, out_int); end
    idle(2);
    model_clear();
    rst_n = 1;
    out_ready = 1;
    for (int i = 90; i < 188; i++) put_byte(8'($urandom), 1'b0, 1'b0);
    idle(10);
    n_checks++;
    if (rx_q.size() != 0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_quiet: got %0d words want 0", rx_q.size()); end
    cfg_write(0, 13'h100, 1);
    send_pkt(13'h100, -1, -1, 0, 0, -1);
    drain(to);
    n_checks++;
    if (to || rx_q.size() != 47 || first_diff() != -1 || pkt_cnt !== 32'd1) begin n_errors++; $display("FAIL rstmid_next: got words=%0d pkt=%0d want 47/1", rx_q.size(), pkt_cnt); end
  endtask

  task automatic test_random();
    bit to; int d; int err_at, cut_at;
    do_reset();
    for (int e = 0; e < 4; e++) cfg_write(e, 13'($urandom_range(16, 27)), ($urandom_range(0, 3) != 0));
    for (int p = 0; p < 40; p++) begin
      m_mode = ($urandom_range(0, 3) == 0);
      filt_mode = m_mode;
      if ($urandom_range(0, 3) == 0) put_byte(8'h46, 1'b1, 1'b0);
      if ($urandom_range(0, 3) == 0) put_byte(8'h47, 1'b0, 1'b0);
      err_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 187) : -1;
      cut_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 187) : -1;
      send_pkt(13'($urandom_range(16, 27)), err_at, cut_at, 1, 0, -1);
    end
    drain(to);
    d = first_diff();
    n_checks += 4;
    if (to || d != -1) begin n_errors++; $display("FAIL rand_stream: got %0d words want %0d, first bad %0d", rx_q.size(), exp_q.size(), d); end
    if (pkt_cnt !== 32'(m_pkt)) begin n_errors++; $display("FAIL rand_pkt: got %0d want %0d", pkt_cnt, m_pkt); end
    if (drop_cnt !== 16'(m_drop)) begin n_errors++; $display("FAIL rand_drop: got %0d want %0d", drop_cnt, m_drop); end
    if (int_seen != m_int) begin n_errors++; $display("FAIL rand_int: got %0d pulses want %0d", int_seen, m_int); end
  endtask

  initial begin
    rst_n = 0; out_ready = 1;
    test_reset();
    test_basic();
    test_filter();
    test_derr();
    test_overflow();
    test_resync();
    test_cfg_collision();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
